// File: rtl/segre_mem_responder.sv
// segre_mem_responder: word-organised memory behind the fetch and data ports.
// Serves one request at a time with a fixed access latency.
module segre_mem_responder #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_req_i,
  input  logic [ADDR_SIZE-1:0] if_addr_i,
  output logic [WORD_SIZE-1:0] if_rdata_o,
  output logic                 if_valid_o,
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  logic [1:0]           dm_size_i,
  input  logic [ADDR_SIZE-1:0] dm_addr_i,
  input  logic [WORD_SIZE-1:0] dm_wdata_i,
  output logic [WORD_SIZE-1:0] dm_rdata_o,
  output logic                 dm_valid_o,
  output logic                 misaligned_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int AW = IW + 2;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  state_t               state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic                 accept;
  logic                 fire;

  logic                 sel_dm;
  logic                 we;
  logic [1:0]           size;
  logic [AW-1:0]        addr;
  logic [WORD_SIZE-1:0] wdata;

  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  logic [IW-1:0]        idx;
  logic [4:0]           sh;
  logic                 mis;
  logic [WORD_SIZE-1:0] word;
  logic [WORD_SIZE-1:0] mask;
  logic [WORD_SIZE-1:0] ld;
  logic [WORD_SIZE-1:0] st;
  logic                 unused_bits;

  assign unused_bits = ^{if_addr_i[ADDR_SIZE-1:AW],
                         dm_addr_i[ADDR_SIZE-1:AW]};

  assign idx    = addr[AW-1:2];
  assign sh     = {addr[1:0], 3'b000};
  assign word   = mem[idx];
  assign busy_o = (state != IDLE);

  always_comb begin
    mis  = 1'b0;
    mask = '1;
    unique case (size)
      2'd0: mask = WORD_SIZE'(8'hff);
      2'd1: begin
        mask = WORD_SIZE'(16'hffff);
        mis  = addr[0];
      end
      default: mis = (addr[1:0] != 2'd0);
    endcase
    ld = (word >> sh) & mask;
    st = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req_i || if_req_i) begin
          accept  = 1'b1;
          state_n = WAIT;
          cnt_n   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          fire    = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Data port wins when both ports ask in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_dm <= 1'b0;
      we     <= 1'b0;
      size   <= 2'd0;
      addr   <= '0;
      wdata  <= '0;
    end else if (accept) begin
      sel_dm <= dm_req_i;
      we     <= dm_we_i;
      size   <= dm_size_i;
      addr   <= dm_req_i ? dm_addr_i[AW-1:0] : if_addr_i[AW-1:0];
      wdata  <= dm_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && fire && sel_dm && we && !mis) begin
      mem[idx] <= st;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_valid_o   <= 1'b0;
      dm_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      if_rdata_o   <= '0;
      dm_rdata_o   <= '0;
    end else begin
      if_valid_o   <= fire && !sel_dm;
      dm_valid_o   <= fire && sel_dm;
      misaligned_o <= fire && sel_dm && mis;
      if (fire && !sel_dm) begin
        if_rdata_o <= word;
      end
      if (fire && sel_dm) begin
        dm_rdata_o <= (we || mis) ? '0 : ld;
      end
    end
  end

endmodule
